// File: rtl/fadd_issue.sv
// fadd_issue: issue/capture wrapper around a handshaked FP32 adder.
//
// Accepts one operand pair from upstream. Presents the pair to the adder
// with a one-cycle start strobe and waits for the adder's result strobe.
// Holds the captured sum until downstream takes it. At most one
// transaction is in flight at any time.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high reset
//   in_valid     upstream operand pair valid
//   in_ready     high in IDLE; an operand pair is accepted when in_valid=1
//   in_op1/2     IEEE-754 single operands
//   fpu_op1/2    registered operands presented to the adder
//   fpu_ready    one-cycle start strobe to the adder (ISSUE state only)
//   fpu_valid    adder result strobe (only honoured in WAIT)
//   fpu_result   adder result, sampled when fpu_valid=1
//   out_valid    captured result available (HOLD state)
//   out_ready    downstream accepts out_result
//   out_result   captured sum
//   busy         high in any state other than IDLE
//   done_count   completed downstream transfers, wraps 16'hFFFF -> 0
//   timeout      sticky WAIT-timeout flag
//
// Optional feature (macro FADD_ISSUE_TIMEOUT_EN):
//   When defined, WAIT is bounded to TIMEOUT_CYCLES cycles. On expiry a
//   quiet NaN (32'h7FC00000) is substituted for the result and the sticky
//   timeout flag is set. When undefined, WAIT lasts until fpu_valid and
//   timeout is tied low.

module fadd_issue #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [31:0] fpu_op1,
    output logic [31:0] fpu_op2,
    output logic        fpu_ready,
    input  logic        fpu_valid,
    input  logic [31:0] fpu_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        busy,
    output logic [15:0] done_count,
    output logic        timeout
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("fadd_issue: TIMEOUT_CYCLES must be within 2..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic load_ops;      // accept the upstream operand pair
    logic cap_result;    // capture the adder result
    logic expire;        // WAIT timed out without a result
    logic wait_expired;  // WAIT counter reached its last cycle
    logic xfer_done;     // downstream transfer completes this cycle

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        load_ops   = 1'b0;
        cap_result = 1'b0;
        expire     = 1'b0;
        xfer_done  = 1'b0;
        in_ready   = 1'b0;
        fpu_ready  = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;

        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    load_ops   = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                fpu_ready  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle takes priority
                if (fpu_valid) begin
                    cap_result = 1'b1;
                    next_state = ST_HOLD;
                end else if (wait_expired) begin
                    expire     = 1'b1;
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    xfer_done  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fpu_op1    <= '0;
            fpu_op2    <= '0;
            out_result <= '0;
            done_count <= '0;
        end else begin
            if (load_ops) begin
                fpu_op1 <= in_op1;
                fpu_op2 <= in_op2;
            end
            if (cap_result) begin
                out_result <= fpu_result;
            end else if (expire) begin
                out_result <= QNAN;
            end
            if (xfer_done) begin
                done_count <= done_count + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Optional WAIT timeout
    // ------------------------------------------------------------------
`ifdef FADD_ISSUE_TIMEOUT_EN
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_cnt;
    logic        timeout_q;

    // wait_cnt holds (WAIT cycle number - 1), so expiry lands on the
    // TIMEOUT_CYCLES-th cycle spent in WAIT.
    assign wait_expired = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT && !fpu_valid && !wait_expired) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (expire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign wait_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

endmodule
